// File: rtl/btn_pkg.sv
// btn_pkg: shared types and 100 MHz default timing for the button conditioner.
package btn_pkg;
    typedef enum logic [1:0] {RPT_IDLE, RPT_ARM, RPT_RUN} rpt_state_t;
    localparam int DEF_CHANNELS      = 5;
    localparam int DEF_STABLE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY  = 50000000;
    localparam int DEF_REPEAT_RATE   = 12500000;
endpackage

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan: one button channel: synchroniser, stability filter, optional repeat.
// Hold-to-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE   = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    logic sync1, sync2, mismatch, accept, rise, fall, rpt_fire;
    logic [SW-1:0] stab_cnt;

    assign mismatch = sync2 != btn_level;
    assign accept   = mismatch && stab_cnt == STAB_MAX;
    assign rise     = accept && sync2;
    assign fall     = accept && !sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            stab_cnt    <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync1       <= btn_in;
            sync2       <= sync1;
            stab_cnt    <= (mismatch && !accept) ? stab_cnt + 1'b1 : '0;
            btn_level   <= accept ? sync2 : btn_level;
            btn_press   <= rise || rpt_fire;
            btn_release <= fall;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    rpt_state_t state, state_nx;
    logic [RW-1:0] rpt_cnt, rpt_cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RPT_IDLE;
            rpt_cnt <= '0;
        end else begin
            state   <= state_nx;
            rpt_cnt <= rpt_cnt_nx;
        end
    end

    // A fall wins over any repeat due in the same cycle.
    always_comb begin
        state_nx   = state;
        rpt_cnt_nx = rpt_cnt + 1'b1;
        rpt_fire   = 1'b0;
        if (fall) begin
            state_nx   = RPT_IDLE;
            rpt_cnt_nx = '0;
        end else if (rise) begin
            state_nx   = RPT_ARM;
            rpt_cnt_nx = '0;
        end else if (state == RPT_ARM && rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
            rpt_fire   = 1'b1;
            state_nx   = RPT_RUN;
            rpt_cnt_nx = '0;
        end else if (state == RPT_RUN && rpt_cnt == RW'(REPEAT_RATE - 1)) begin
            rpt_fire   = 1'b1;
            rpt_cnt_nx = '0;
        end else if (state == RPT_IDLE) begin
            rpt_cnt_nx = '0;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif
endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: CHANNELS independent debounced buttons with press/release pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-auto-repeat on btn_press.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE   = DEF_REPEAT_RATE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release
);
    if (CHANNELS < 1) begin : g_bad_channels
        $error("CHANNELS must be at least 1");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        btn_debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .btn_in     (btn_in[c]),
            .btn_level  (btn_level[c]),
            .btn_press  (btn_press[c]),
            .btn_release(btn_release[c])
        );
    end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: scoreboard bench with a per-edge reference model of the conditioner.
module tb_btn_debounce_multi;
    localparam int CH = 4, S = 8, D = 20, R = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [CH-1:0] btn_in = '1;
    logic [CH-1:0] btn_level, btn_press, btn_release;

    btn_debounce_multi #(.CHANNELS(CH), .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [3*CH-1:0] exp_q[$];

    // Reference: level flips after S consecutive mismatching synchronised samples;
    // repeats land at T+D+n*R while the accepted level stays high.
    logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
    int m_run[CH];
    int m_t0[CH];
    always @(posedge clk) begin
        logic [CH-1:0] p, r;
        cyc++;
        p = '0;
        r = '0;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            m_lvl = '0;
            for (int i = 0; i < CH; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                m_run[i] = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == S) begin
                    m_run[i] = 0;
                    m_lvl[i] = m_s2[i];
                    if (m_s2[i]) begin
                        p[i] = 1'b1;
                        m_t0[i] = cyc;
                    end else r[i] = 1'b1;
                end else if (AR && m_lvl[i] && cyc - m_t0[i] >= D && (cyc - m_t0[i] - D) % R == 0)
                    p[i] = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
        exp_q.push_back({m_lvl, p, r});
    end

    bit win = 1'b0;
    int win_p = 0, win_r = 0;
    always @(posedge clk) begin
        logic [3*CH-1:0] e;
        #1;
        if (win) begin
            win_p += int'(btn_press[0]);
            win_r += int'(btn_release[0]);
        end
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty cyc=%0d got none required one entry", cyc);
        end else begin
            e = exp_q.pop_front();
            n_chk += 2;
            if (btn_level !== e[3*CH-1:2*CH]) begin
                n_fail++;
                $display("FAIL level cyc=%0d got %h required %h", cyc, btn_level, e[3*CH-1:2*CH]);
            end
            if (btn_press !== e[2*CH-1:CH]) begin
                n_fail++;
                $display("FAIL press cyc=%0d got %h required %h", cyc, btn_press, e[2*CH-1:CH]);
            end
            if (btn_release !== e[CH-1:0]) begin
                n_fail++;
                $display("FAIL release cyc=%0d got %h required %h", cyc, btn_release, e[CH-1:0]);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_bit(input int ch, input logic v);
        btn_in[ch] = v;
    endtask

    initial begin
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(15);
        btn_in = '0;
        wait_cyc(15);
        win = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_bit(0, ~btn_in[0]);
            wait_cyc(3);
        end
        set_bit(0, 1'b1);
        wait_cyc(20);
        win = 1'b0;
        @(posedge clk);
        #2;
        n_chk += 2;
        if (win_p != 1) begin
            n_fail++;
            $display("FAIL bounce_press_count got %0d required 1", win_p);
        end
        if (win_r != 0) begin
            n_fail++;
            $display("FAIL bounce_release_count got %0d required 0", win_r);
        end
        @(negedge clk);
        set_bit(1, 1'b1);
        wait_cyc(7);
        set_bit(1, 1'b0);
        wait_cyc(15);
        set_bit(1, 1'b1);
        wait_cyc(8);
        set_bit(1, 1'b0);
        wait_cyc(15);
        set_bit(2, 1'b1);
        wait_cyc(70);
        set_bit(2, 1'b0);
        wait_cyc(15);
        btn_in[3] = 1'b1;
        btn_in[0] = 1'b0;
        wait_cyc(15);
        set_bit(3, 1'b0);
        wait_cyc(15);
        set_bit(2, 1'b1);
        wait_cyc(42);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        set_bit(2, 1'b0);
        wait_cyc(15);
        set_bit(2, 1'b1);
        wait_cyc(40);
        set_bit(2, 1'b0);
        wait_cyc(15);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 11) == 0) set_bit(i, ~btn_in[i]);
            rst = ($urandom_range(0, 799) == 0);
            wait_cyc(1);
        end
        rst = 1'b0;
        wait_cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
